// File: rtl/level_pkg.sv
// Shared types and classification for the tank-level sensor path.
// The level codes match what the 7-segment display stage decodes.
package level_pkg;

   typedef enum logic [1:0] {
      LVL_HIGH  = 2'b00,
      LVL_MID   = 2'b01,
      LVL_LOW   = 2'b10,
      LVL_FAULT = 2'b11
   } level_t;

   typedef enum logic [1:0] {
      S_INIT,
      S_RUN,
      S_SUSPECT,
      S_FAULT
   } state_t;

   // pair = {hi, lo}; hi wet with lo dry cannot happen physically
   function automatic level_t pair_to_level(input logic [1:0] pair);
      level_t lvl;
      case (pair)
         2'b11:   lvl = LVL_HIGH;
         2'b01:   lvl = LVL_MID;
         2'b00:   lvl = LVL_LOW;
         default: lvl = LVL_FAULT;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a candidate/counter debouncer.
// o_stable is high once the synced value has held for CYCLES samples.
module sensor_debounce #(
   parameter int WIDTH  = 2,
   parameter int CYCLES = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_cand,
   output logic             o_stable
);

   localparam int CNT_W = $clog2(CYCLES) + 1;
   localparam logic [CNT_W-1:0] DMAX = CNT_W'(CYCLES - 1);

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;
   logic [WIDTH-1:0] r_cand;
   logic [CNT_W-1:0] r_dcnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_cand <= '0;
         r_dcnt <= '0;
      end else begin
         r_s1 <= i_async;
         r_s2 <= r_s1;
         if (r_s2 != r_cand) begin
            r_cand <= r_s2;
            r_dcnt <= '0;
         end else if (r_dcnt != DMAX) begin
            r_dcnt <= r_dcnt + CNT_W'(1);
         end
      end
   end

   assign o_cand   = r_cand;
   assign o_stable = (r_s2 == r_cand) && (r_dcnt == DMAX);

endmodule

// File: rtl/level_sensor_monitor.sv
// Tank-level probe monitor: debounces the 80%/30% probes, classifies
// the level and confirms probe faults before latching them.
module level_sensor_monitor
   import level_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FAULT_CYCLES    = 8
) (
   input  logic       clk_2,
   input  logic       reset_n,
   input  logic       sens_hi,
   input  logic       sens_lo,
   input  logic       fault_clr,
   output logic [1:0] level_code,
   output logic       level_valid,
   output logic       level_chg,
   output logic       fault_sticky
);

   localparam int MAXC  = (DEBOUNCE_CYCLES > FAULT_CYCLES) ?
                          DEBOUNCE_CYCLES : FAULT_CYCLES;
   localparam int CNT_W = $clog2(MAXC) + 1;
   localparam logic [CNT_W-1:0] FMAX = CNT_W'(FAULT_CYCLES - 1);

   logic [1:0]       w_cand;
   logic             w_stable;
   level_t           w_lvl;
   logic             w_inv;
   logic             w_st_ok;
   logic             w_st_inv;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_fcnt;
   logic [CNT_W-1:0] w_fcnt_nxt;

   level_t           r_code;
   level_t           w_code_nxt;
   logic             r_valid;
   logic             w_valid_nxt;
   logic             r_chg;
   logic             r_sticky;
   logic             w_sticky_nxt;

   sensor_debounce #(
      .WIDTH  (2),
      .CYCLES (DEBOUNCE_CYCLES)
   ) u_deb (
      .i_clk    (clk_2),
      .i_rst_n  (reset_n),
      .i_async  ({sens_hi, sens_lo}),
      .o_cand   (w_cand),
      .o_stable (w_stable)
   );

   assign w_lvl    = pair_to_level(w_cand);
   assign w_inv    = (w_lvl == LVL_FAULT);
   assign w_st_ok  = w_stable && !w_inv;
   assign w_st_inv = w_stable && w_inv;

   always_ff @(posedge clk_2) begin
      if (!reset_n) begin
         r_state  <= S_INIT;
         r_fcnt   <= '0;
         r_code   <= LVL_FAULT;
         r_valid  <= 1'b0;
         r_chg    <= 1'b0;
         r_sticky <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_fcnt   <= w_fcnt_nxt;
         r_code   <= w_code_nxt;
         r_valid  <= w_valid_nxt;
         r_chg    <= (w_code_nxt != r_code);
         r_sticky <= w_sticky_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fcnt_nxt  = r_fcnt;
      unique case (r_state)
         S_INIT: begin
            if (w_st_ok) begin
               w_state_nxt = S_RUN;
            end else if (w_st_inv) begin
               w_state_nxt = S_SUSPECT;
               w_fcnt_nxt  = '0;
            end
         end
         S_RUN: begin
            if (w_st_inv) begin
               w_state_nxt = S_SUSPECT;
               w_fcnt_nxt  = '0;
            end
         end
         S_SUSPECT: begin
            // any valid candidate, even unstable, drops the suspicion
            if (!w_inv) begin
               w_state_nxt = r_valid ? S_RUN : S_INIT;
               w_fcnt_nxt  = '0;
            end else if (w_stable) begin
               if (r_fcnt == FMAX) begin
                  w_state_nxt = S_FAULT;
                  w_fcnt_nxt  = '0;
               end else begin
                  w_fcnt_nxt = r_fcnt + CNT_W'(1);
               end
            end
         end
         S_FAULT: begin
            if (fault_clr && w_st_ok) begin
               w_state_nxt = S_RUN;
            end
         end
      endcase
   end

   always_comb begin
      w_code_nxt   = r_code;
      w_valid_nxt  = r_valid;
      w_sticky_nxt = r_sticky;
      unique case (r_state)
         S_INIT: begin
            if (w_st_ok) begin
               w_code_nxt  = w_lvl;
               w_valid_nxt = 1'b1;
            end
         end
         S_RUN: begin
            if (w_st_ok) begin
               w_code_nxt = w_lvl;
            end
         end
         S_SUSPECT: begin
            if (w_st_inv && (r_fcnt == FMAX)) begin
               w_code_nxt   = LVL_FAULT;
               w_valid_nxt  = 1'b1;
               w_sticky_nxt = 1'b1;
            end
         end
         S_FAULT: begin
            if (fault_clr && w_st_ok) begin
               w_code_nxt   = w_lvl;
               w_sticky_nxt = 1'b0;
            end
         end
      endcase
   end

   assign level_code   = r_code;
   assign level_valid  = r_valid;
   assign level_chg    = r_chg;
   assign fault_sticky = r_sticky;

endmodule
